// File: rtl/nasti_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nasti_pkg
// Purpose  : Shared NASTI definitions: response codes and the state encodings
//            of the error-slave write and read state machines.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nasti_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/nasti_err_slave.sv
`default_nettype none
// ============================================================================
// Module   : nasti_err_slave
// Purpose  : Escape responder for undecoded NASTI transactions. Accepts every
//            AW/W/AR and answers with DECERR: one B per write burst and
//            len+1 R beats per read burst. Write and read sides are
//            independent, one outstanding transaction each.
// Ports    : clk, rst (async, active high)
//            AW: aw_valid/aw_ready/aw_id/aw_addr/aw_len
//            W : w_valid/w_ready/w_last
//            B : b_valid/b_ready/b_id/b_resp/b_user
//            AR: ar_valid/ar_ready/ar_id/ar_addr/ar_len
//            R : r_valid/r_ready/r_id/r_data/r_resp/r_last/r_user
//            Optional (NASTI_ERR_SLAVE_CAPTURE_EN): err_addr, err_is_write,
//            err_cnt - last accepted address, its direction, and a
//            saturating count of accepted addresses.
// Revision : 1.0 - initial release
// ============================================================================
module nasti_err_slave
  import nasti_pkg::*;
#(
  parameter int         ID_WIDTH   = 1,
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 8,
  parameter int         USER_WIDTH = 1,
  parameter int         LITE_MODE  = 0,
  parameter logic [7:0] FILL_BYTE  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]            aw_len,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic                  w_last,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic [USER_WIDTH-1:0] b_user,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]            ar_len,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic [USER_WIDTH-1:0] r_user
`ifdef NASTI_ERR_SLAVE_CAPTURE_EN
  ,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_is_write,
  output logic [15:0]           err_cnt
`endif
);

  wr_state_e           r_wr_state;
  rd_state_e           r_rd_state;
  logic [ID_WIDTH-1:0] r_bid;
  logic [ID_WIDTH-1:0] r_rid;
  logic [7:0]          r_cnt;

  logic w_aw_hs;
  logic w_ar_hs;
  logic w_burst_end;

  assign w_aw_hs     = aw_valid && (r_wr_state == W_IDLE);
  assign w_ar_hs     = ar_valid && (r_rd_state == R_IDLE);
  // In Lite mode every write is a single beat, so w_last is irrelevant.
  assign w_burst_end = w_valid && (w_last || (LITE_MODE != 0));

  // Write side: accept address, swallow data until the last beat, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_bid      <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (aw_valid) begin
            r_bid      <= aw_id;
            r_wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_burst_end) r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (b_ready) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read side: counter is reloaded only from idle, so len=255 yields exactly
  // 256 beats without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rid      <= '0;
      r_cnt      <= 8'd0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (ar_valid) begin
            r_rid      <= ar_id;
            r_cnt      <= (LITE_MODE != 0) ? 8'd0 : ar_len;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready) begin
            if (r_cnt == 8'd0) r_rd_state <= R_IDLE;
            else               r_cnt      <= r_cnt - 8'd1;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state registers only.
  assign aw_ready = (r_wr_state == W_IDLE);
  assign w_ready  = (r_wr_state == W_DATA);
  assign b_valid  = (r_wr_state == W_RESP);
  assign b_id     = r_bid;
  assign b_resp   = RESP_DECERR;
  assign b_user   = '0;

  assign ar_ready = (r_rd_state == R_IDLE);
  assign r_valid  = (r_rd_state == R_DATA);
  assign r_id     = r_rid;
  assign r_data   = {(DATA_WIDTH/8){FILL_BYTE}};
  assign r_resp   = RESP_DECERR;
  assign r_last   = (r_rd_state == R_DATA) && (r_cnt == 8'd0);
  assign r_user   = '0;

`ifdef NASTI_ERR_SLAVE_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_is_write;
  logic [15:0]           r_err_cnt;
  logic [16:0]           w_cnt_sum;

  // A same-cycle AW+AR adds two; the 17th bit flags saturation.
  assign w_cnt_sum = {1'b0, r_err_cnt} + {16'd0, w_aw_hs} + {16'd0, w_ar_hs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_addr     <= '0;
      r_err_is_write <= 1'b0;
      r_err_cnt      <= 16'd0;
    end else begin
      // AR wins a same-cycle tie.
      if (w_ar_hs) begin
        r_err_addr     <= ar_addr;
        r_err_is_write <= 1'b0;
      end else if (w_aw_hs) begin
        r_err_addr     <= aw_addr;
        r_err_is_write <= 1'b1;
      end
      r_err_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign err_addr     = r_err_addr;
  assign err_is_write = r_err_is_write;
  assign err_cnt      = r_err_cnt;

  logic w_unused_ok;
  assign w_unused_ok = ^{aw_len};
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{aw_len, aw_addr, ar_addr, w_aw_hs, w_ar_hs};
`endif

endmodule
`default_nettype wire

// File: doc/nasti_err_slave.md
Name: nasti_err_slave

Overview:
- Default/escape responder that terminates NASTI transactions no real slave decodes.
- Sits directly downstream of the address-decoding demux on its escape output port 0, with escaping enabled there.
- Accepts every AW/W/AR presented to it and answers each with DECERR: one B per write burst, len+1 R beats per read burst.
- Read and write sides are independent state machines; one outstanding transaction per side.

Parameters:
- ID_WIDTH, 1, transaction id width.
- ADDR_WIDTH, 8, address width; used only by the optional capture feature.
- DATA_WIDTH, 8, R data width.
- USER_WIDTH, 1, user field width; b_user and r_user are driven 0.
- LITE_MODE, 0, 1 = NASTI-Lite: aw_len/ar_len ignored, every burst is one beat, w_last ignored.
- FILL_BYTE, 8'h00, byte replicated across r_data on every error beat.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- aw_valid, aw_id, aw_addr, aw_len  in  1, ID_WIDTH, ADDR_WIDTH, 8  write address; other AW fields are accepted and ignored.
- aw_ready  out  1  write address ready
- w_valid, w_last  in  1, 1  write data; w_data, w_strb and w_user are ignored.
- w_ready  out  1  write data ready
- b_valid, b_id, b_resp, b_user  out  1, ID_WIDTH, 2, USER_WIDTH  write response
- b_ready  in  1  write response ready
- ar_valid, ar_id, ar_addr, ar_len  in  1, ID_WIDTH, ADDR_WIDTH, 8  read address; other AR fields are ignored.
- ar_ready  out  1  read address ready
- r_valid, r_id, r_data, r_resp, r_last, r_user  out  1, ID_WIDTH, DATA_WIDTH, 2, 1, USER_WIDTH  read data
- r_ready  in  1  read data ready

Behaviour:
Write FSM, states W_IDLE, W_DATA, W_RESP; reset state W_IDLE.
- W_IDLE:
  - aw_ready=1, w_ready=0.
  - On aw_valid&&aw_ready: latch aw_id, go to W_DATA.
  - W beats arriving before their AW are not accepted.
- W_DATA:
  - w_ready=1, aw_ready=0.
  - Each w_valid beat is consumed and discarded.
  - On the handshake of a beat with w_last=1 (any beat when LITE_MODE=1): go to W_RESP.
  - aw_len is not checked against the beat count; w_last alone ends the burst.
- W_RESP:
  - b_valid=1, b_id=latched id, b_resp=2'b11 (DECERR).
  - On b_ready: go to W_IDLE.
  - b_ready held low stalls the FSM indefinitely; aw_ready and w_ready stay 0.
- Earliest B is one cycle after the w_last handshake. Minimum write turnaround is 3 cycles for a 1-beat burst.

Read FSM, states R_IDLE, R_DATA; reset state R_IDLE.
- R_IDLE:
  - ar_ready=1.
  - On handshake: latch ar_id; load 8-bit beat counter with ar_len (0 when LITE_MODE=1); go to R_DATA.
- R_DATA:
  - ar_ready=0, r_valid=1, r_resp=2'b11, r_data={DATA_WIDTH/8{FILL_BYTE}}, r_id=latched id.
  - r_last=(cnt==0).
  - On r_valid&&r_ready: if cnt==0 go to R_IDLE, else cnt<=cnt-1.
- ar_len=8'hFF gives 256 beats; the counter never wraps because it is reloaded only in R_IDLE.
- First R beat is one cycle after the AR handshake. r_data/r_id are stable while r_valid is high and r_ready is low.

Concurrency and reset:
- AW and AR handshakes in the same cycle are both accepted.
- The two FSMs never share state.
- All ready/valid outputs are decoded from state registers only; there is no combinational path from any input valid/ready to any output.
- While rst=1: both FSMs sit in idle, b_valid=0, r_valid=0, w_ready=0, aw_ready=1, ar_ready=1, latched ids=0, cnt=0.
  - Upstream holds valids low during reset, so ready=1 is harmless.
- rst asserted mid-burst abandons the burst immediately. No B or remaining R beats are issued after release.

Optional Feature:
- Macro NASTI_ERR_SLAVE_CAPTURE_EN. When defined, three extra outputs are added:
  - err_addr [ADDR_WIDTH]: address of the most recently accepted AW or AR. AR wins a same-cycle tie.
  - err_is_write [1]: 1 if err_addr came from an AW.
  - err_cnt [16]: accepted-address count; saturates at 16'hFFFF and does not wrap. A same-cycle AW+AR adds 2.
  - All three reset to 0.
- When not defined, these ports and registers do not exist and aw_addr/ar_addr are unused.

Decomposition:
- nasti_pkg holds:
  - the response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the enum types for the write and read FSM states.
- No sub-module. Both FSMs live in one module; each is small enough that splitting adds only port boilerplate.

Test Plan:
- AW id=1 len=0, one W beat with w_last=1, b_ready=1 -> b_valid one cycle later, b_id=1, b_resp=2'b11, exactly one B.
- AR id=0 len=3, r_ready=1, FILL_BYTE=8'hA5, DATA_WIDTH=32 -> 4 consecutive beats of 32'hA5A5A5A5, r_resp=2'b11, r_last only on beat 4.
- AR len=8'hFF with r_ready toggling every other cycle -> exactly 256 beats, r_data/r_id stable across stalls, ar_ready=0 until the last handshake.
- Simultaneous AW id=1 and AR id=0, b_ready held 0 for 10 cycles -> R burst completes unaffected; B is held; aw_ready=0 until the B handshake.
- W beats before AW, then rst pulsed mid read burst after 2 of 5 beats -> w_ready=0 before AW; after reset r_valid=0, no leftover beats, ar_ready=1.
- With NASTI_ERR_SLAVE_CAPTURE_EN: AW addr=0x40, then AR addr=0x80 -> err_addr=0x80, err_is_write=0, err_cnt=2.
